// File: rtl/spi_dac_dpot_tx_pkg.sv
// ---------------------------------------------------------------------------
// spi_dac_dpot_tx_pkg
// Shared types and constants for the DAC / digital-potentiometer serial
// transmitter: FSM state encoding, frame target selector and the default
// frame lengths.
// ---------------------------------------------------------------------------
package spi_dac_dpot_tx_pkg;

  localparam int DAC_BITS_DEF  = 16;
  localparam int DPOT_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_END   = 2'd3
  } state_e;

  typedef enum logic {
    TGT_DAC  = 1'b0,
    TGT_DPOT = 1'b1
  } target_e;

endpackage

// File: rtl/spi_dac_dpot_tx_phase_tick.sv
// ---------------------------------------------------------------------------
// spi_phase_tick
// Clock divider for the serial bus. While en_i is high it counts CLK_DIV
// clk cycles and pulses tick_o on the last cycle of each phase, then
// reloads. While en_i is low the counter is held cleared, so the first
// phase after enabling is always a full CLK_DIV cycles long.
//
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   en_i    count enable
//   tick_o  1-cycle phase-end strobe
// ---------------------------------------------------------------------------
module spi_phase_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear when idle, reload at the phase end, else increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_dac_dpot_tx.sv
// ---------------------------------------------------------------------------
// spi_dac_dpot_tx
// Serial output stage for a DAC and four digital potentiometers sharing one
// three-wire bus. A start request in IDLE latches the word, then the FSM
// walks SETUP (select low, MSB on sdo), SHIFT (N sclk periods, data changes
// on the falling edge) and END (select released, done pulse).
//
// All bus outputs are registered from the current FSM state, so they appear
// one clock after the state that produces them; this gives the select its
// "start edge + 1" timing and lines done up with the select release.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   dac_start_i          1-cycle request to send dac_word_i (wins ties)
//   dac_word_i           DAC word, MSB first
//   dpot_start_i         1-cycle request to send dpot_word_i
//   dpot_word_i          wiper value, MSB first
//   dpot_sel_i           potentiometer index 0..3
//   busy_o               frame in progress
//   done_o               1-cycle end-of-frame pulse
//   sclk_o, sdo_o        serial clock (idles low) and data
//   dac_sync_n_o         DAC frame sync, active low
//   dpot_cs_n_o          potentiometer chip selects, one-hot active low
// ---------------------------------------------------------------------------
module spi_dac_dpot_tx
  import spi_dac_dpot_tx_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int DAC_BITS  = DAC_BITS_DEF,
  parameter int DPOT_BITS = DPOT_BITS_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dac_start_i,
  input  logic [DAC_BITS-1:0]  dac_word_i,
  input  logic                 dpot_start_i,
  input  logic [DPOT_BITS-1:0] dpot_word_i,
  input  logic [1:0]           dpot_sel_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sclk_o,
  output logic                 sdo_o,
  output logic                 dac_sync_n_o,
  output logic [3:0]           dpot_cs_n_o
);

  localparam int BW = $clog2(DAC_BITS + 1);

  state_e              state_q, state_d;
  target_e             tgt_q, tgt_d;
  logic [1:0]          sel_q, sel_d;
  logic [DAC_BITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                phase_hi_q, phase_hi_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sclk_q, sclk_d;
  logic                sdo_q, sdo_d;
  logic                sync_n_q, sync_n_d;
  logic [3:0]          cs_n_q, cs_n_d;

  logic                frame_s;
  logic                tick_s;

  assign frame_s = (state_q == ST_SETUP) || (state_q == ST_SHIFT);

  spi_phase_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (frame_s),
    .tick_o (tick_s)
  );

  // FSM next-state, word latch, shift register and bit counter.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    sel_d      = sel_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    phase_hi_d = phase_hi_q;
    case (state_q)
      ST_IDLE: begin
        if (dac_start_i) begin
          shreg_d   = dac_word_i;
          tgt_d     = TGT_DAC;
          bit_cnt_d = BW'(DAC_BITS);
          state_d   = ST_SETUP;
        end else if (dpot_start_i) begin
          // Left-justify the wiper word so the MSB sits at the shift output.
          shreg_d   = DAC_BITS'(dpot_word_i) << (DAC_BITS - DPOT_BITS);
          sel_d     = dpot_sel_i;
          tgt_d     = TGT_DPOT;
          bit_cnt_d = BW'(DPOT_BITS);
          state_d   = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tick_s) begin
          state_d    = ST_SHIFT;
          phase_hi_d = 1'b1;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        if (tick_s) begin
          if (phase_hi_q) begin
            // Falling sclk edge: one bit consumed; present the next bit
            // unless this was the last one.
            phase_hi_d = 1'b0;
            bit_cnt_d  = bit_cnt_q - BW'(1);
            if (bit_cnt_q != BW'(1)) begin
              shreg_d = {shreg_q[DAC_BITS-2:0], 1'b0};
            end else begin
              shreg_d = shreg_q;
            end
          end else if (bit_cnt_q == '0) begin
            state_d = ST_END;
          end else begin
            phase_hi_d = 1'b1;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the current state; registered below.
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_q == ST_END);
    sclk_d   = (state_q == ST_SHIFT) && phase_hi_q;
    sdo_d    = 1'b0;
    sync_n_d = 1'b1;
    cs_n_d   = 4'b1111;
    if (frame_s) begin
      sdo_d = shreg_q[DAC_BITS-1];
      if (tgt_q == TGT_DAC) begin
        sync_n_d = 1'b0;
      end else begin
        cs_n_d = ~(4'b0001 << sel_q);
      end
    end else begin
      sdo_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tgt_q      <= TGT_DAC;
      sel_q      <= 2'd0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      phase_hi_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      sel_q      <= sel_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_hi_q <= phase_hi_d;
    end
  end

  // Registered bus and status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sdo_q    <= 1'b0;
      sync_n_q <= 1'b1;
      cs_n_q   <= 4'b1111;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      sdo_q    <= sdo_d;
      sync_n_q <= sync_n_d;
      cs_n_q   <= cs_n_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign sclk_o       = sclk_q;
  assign sdo_o        = sdo_q;
  assign dac_sync_n_o = sync_n_q;
  assign dpot_cs_n_o  = cs_n_q;

endmodule

// File: tb/tb_spi_dac_dpot_tx.sv
// Bench for spi_dac_dpot_tx: two instances (CLK_DIV=2 and CLK_DIV=1) share
// the same stimulus. A frame-level reference model predicts every output
// each cycle from the start edge and the frame arithmetic; a table of
// frames checks captured bits and select low times; hand sequences cover
// start-while-busy and asynchronous reset mid-frame.
module tb_spi_dac_dpot_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dac_start = 1'b0;
  logic        dpot_start = 1'b0;
  logic [15:0] dac_word = 16'h0000;
  logic [7:0]  dpot_word = 8'h00;
  logic [1:0]  dpot_sel = 2'd0;

  logic [1:0]  busy_w, done_w, sclk_w, sdo_w, sync_w;
  logic [3:0]  cs_w [2];

  always #5 clk = ~clk;

  spi_dac_dpot_tx #(.CLK_DIV(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .dac_start_i(dac_start), .dac_word_i(dac_word),
    .dpot_start_i(dpot_start), .dpot_word_i(dpot_word), .dpot_sel_i(dpot_sel),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .sclk_o(sclk_w[0]), .sdo_o(sdo_w[0]),
    .dac_sync_n_o(sync_w[0]), .dpot_cs_n_o(cs_w[0]));

  spi_dac_dpot_tx #(.CLK_DIV(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .dac_start_i(dac_start), .dac_word_i(dac_word),
    .dpot_start_i(dpot_start), .dpot_word_i(dpot_word), .dpot_sel_i(dpot_sel),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .sclk_o(sclk_w[1]), .sdo_o(sdo_w[1]),
    .dac_sync_n_o(sync_w[1]), .dpot_cs_n_o(cs_w[1]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // reference model state per instance
  int          cd [2] = '{2, 1};
  bit          act [2] = '{1'b0, 1'b0};
  int          t0 [2];
  logic [15:0] mword [2];
  bit          mdac [2];
  logic [1:0]  msel [2];
  int          mn [2];

  // frame monitors
  int          rise_cnt [2];
  logic [15:0] cap [2];
  int          sync_low [2];
  int          cs_low [2];
  int          done_cnt [2];
  logic [3:0]  cs_seen [2];
  logic        prev_sclk [2] = '{1'b0, 1'b0};

  typedef struct {
    bit          do_dac;
    bit          do_dpot;
    logic [15:0] dw;
    logic [7:0]  pw;
    logic [1:0]  ps;
    logic [15:0] exp_bits;
    int          exp_n;
    int          exp_low2;
    int          exp_low1;
    bit          exp_dac;
    logic [3:0]  exp_cs;
  } vec_t;

  vec_t tbl [6];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // model update at a rising edge, using the inputs present at that edge
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] = 1'b0;
      end else begin
        if (act[i] && cyc >= t0[i] + cd[i] * (1 + 2 * mn[i]) + 2) act[i] = 1'b0;
        if (!act[i]) begin
          if (dac_start) begin
            act[i] = 1'b1; t0[i] = cyc; mword[i] = dac_word; mdac[i] = 1'b1; mn[i] = 16;
          end else if (dpot_start) begin
            act[i] = 1'b1; t0[i] = cyc; mword[i] = {dpot_word, 8'h00};
            mdac[i] = 1'b0; msel[i] = dpot_sel; mn[i] = 8;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      logic eb, ed, es, esync, esdo, chk_sdo;
      logic [3:0] ecs;
      int lf, dend, t, u, idx;
      eb = 1'b0; ed = 1'b0; es = 1'b0; esync = 1'b1; ecs = 4'hF; esdo = 1'b0; chk_sdo = 1'b0;
      if (act[i]) begin
        lf = cd[i] * (1 + 2 * mn[i]);
        dend = t0[i] + 1 + lf;
        eb = (cyc < dend);
        ed = (cyc == dend);
        if (cyc >= t0[i] + 1 && cyc < dend) begin
          t = cyc - t0[i] - 1;
          if (mdac[i]) esync = 1'b0;
          else ecs = ~(4'b0001 << msel[i]);
          if (t < cd[i]) begin
            es = 1'b0; idx = 0;
          end else begin
            u = t - cd[i];
            es = ((u / cd[i]) % 2) == 0;
            idx = (u + cd[i]) / (2 * cd[i]);
            if (idx > mn[i] - 1) idx = mn[i] - 1;
          end
          esdo = mword[i][15 - idx];
          chk_sdo = 1'b1;
        end
      end
      cmp($sformatf("cyc_ctl_dut%0d", i),
          {24'h0, busy_w[i], done_w[i], sclk_w[i], sync_w[i], cs_w[i]},
          {24'h0, eb, ed, es, esync, ecs});
      if (chk_sdo) cmp($sformatf("cyc_sdo_dut%0d", i), {31'h0, sdo_w[i]}, {31'h0, esdo});
      // monitor
      if (sclk_w[i] && !prev_sclk[i]) begin
        rise_cnt[i]++;
        cap[i] = {cap[i][14:0], sdo_w[i]};
      end
      prev_sclk[i] = sclk_w[i];
      if (!sync_w[i]) sync_low[i]++;
      if (cs_w[i] != 4'hF) begin cs_low[i]++; cs_seen[i] = cs_w[i]; end
      if (done_w[i]) done_cnt[i]++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check_outputs();
    dac_start = 1'b0;
    dpot_start = 1'b0;
  endtask

  task automatic mon_reset();
    for (int i = 0; i < 2; i++) begin
      rise_cnt[i] = 0; cap[i] = 16'h0; sync_low[i] = 0; cs_low[i] = 0;
      done_cnt[i] = 0; cs_seen[i] = 4'hF;
    end
  endtask

  task automatic check_full_dac(input string name, input logic [15:0] w);
    for (int i = 0; i < 2; i++) begin
      cmp($sformatf("%s_edges_dut%0d", name, i), rise_cnt[i], 16);
      cmp($sformatf("%s_bits_dut%0d", name, i), {16'h0, cap[i]}, {16'h0, w});
      cmp($sformatf("%s_done_dut%0d", name, i), done_cnt[i], 1);
      cmp($sformatf("%s_synclow_dut%0d", name, i), sync_low[i], (i == 0) ? 66 : 33);
    end
  endtask

  initial begin
    logic [15:0] mask;
    int waited;

    tbl[0] = '{1'b1, 1'b0, 16'hE800, 8'h00, 2'd0, 16'hE800, 16, 66, 33, 1'b1, 4'hF};
    tbl[1] = '{1'b0, 1'b1, 16'h0000, 8'h81, 2'd2, 16'h0081, 8, 34, 17, 1'b0, 4'b1011};
    tbl[2] = '{1'b1, 1'b0, 16'hA5C3, 8'h00, 2'd0, 16'hA5C3, 16, 66, 33, 1'b1, 4'hF};
    tbl[3] = '{1'b0, 1'b1, 16'h0000, 8'h7E, 2'd0, 16'h007E, 8, 34, 17, 1'b0, 4'b1110};
    tbl[4] = '{1'b1, 1'b1, 16'h1234, 8'h55, 2'd1, 16'h1234, 16, 66, 33, 1'b1, 4'hF};
    tbl[5] = '{1'b0, 1'b1, 16'h0000, 8'hFF, 2'd3, 16'h00FF, 8, 34, 17, 1'b0, 4'b0111};

    mon_reset();
    repeat (3) step();  // reset values checked every cycle
    rst = 1'b0;
    repeat (2) step();

    // table-driven frames
    for (int v = 0; v < 6; v++) begin
      mon_reset();
      dac_word = tbl[v].dw; dpot_word = tbl[v].pw; dpot_sel = tbl[v].ps;
      dac_start = tbl[v].do_dac; dpot_start = tbl[v].do_dpot;
      step();
      dpot_sel = 2'd0;  // latched select must not follow the live input
      repeat (75) step();
      mask = 16'((32'h1 << tbl[v].exp_n) - 32'h1);
      for (int i = 0; i < 2; i++) begin
        cmp($sformatf("tbl%0d_edges_dut%0d", v, i), rise_cnt[i], tbl[v].exp_n);
        cmp($sformatf("tbl%0d_bits_dut%0d", v, i), {16'h0, cap[i] & mask}, {16'h0, tbl[v].exp_bits});
        cmp($sformatf("tbl%0d_done_dut%0d", v, i), done_cnt[i], 1);
        if (tbl[v].exp_dac) begin
          cmp($sformatf("tbl%0d_synclow_dut%0d", v, i), sync_low[i], (i == 0) ? tbl[v].exp_low2 : tbl[v].exp_low1);
          cmp($sformatf("tbl%0d_cslow_dut%0d", v, i), cs_low[i], 0);
        end else begin
          cmp($sformatf("tbl%0d_synclow_dut%0d", v, i), sync_low[i], 0);
          cmp($sformatf("tbl%0d_cslow_dut%0d", v, i), cs_low[i], (i == 0) ? tbl[v].exp_low2 : tbl[v].exp_low1);
          cmp($sformatf("tbl%0d_cspat_dut%0d", v, i), {28'h0, cs_seen[i]}, {28'h0, tbl[v].exp_cs});
        end
      end
    end

    // start while busy: second request at start+10 is dropped
    mon_reset();
    dac_word = 16'hC3A5; dac_start = 1'b1;
    step();
    repeat (9) step();
    dac_word = 16'h0F0F; dac_start = 1'b1;
    step();
    repeat (70) step();
    check_full_dac("busy_start", 16'hC3A5);

    // asynchronous reset in the middle of bit 5
    mon_reset();
    dac_word = 16'hFFFF; dac_start = 1'b1;
    step();
    waited = 0;
    while (rise_cnt[0] < 5 && waited < 60) begin
      step();
      waited++;
    end
    cmp("rst_wait_bit5", {31'h0, (rise_cnt[0] >= 5)}, 32'h1);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      cmp($sformatf("rst_async_dut%0d", i),
          {24'h0, busy_w[i], done_w[i], sclk_w[i], sync_w[i], cs_w[i]},
          {24'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF});
      act[i] = 1'b0;
    end
    step();
    step();
    rst = 1'b0;
    step();
    mon_reset();
    dac_word = 16'h9C31; dac_start = 1'b1;
    step();
    repeat (75) step();
    check_full_dac("after_rst", 16'h9C31);

    // randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      dac_word = 16'($urandom);
      dpot_word = 8'($urandom);
      dpot_sel = 2'($urandom_range(0, 3));
      dac_start = ($urandom_range(0, 19) == 0);
      dpot_start = ($urandom_range(0, 14) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_dac_dpot_tx.md
# spi_dac_dpot_tx

Serial output stage directly downstream of the command/control logic. It accepts a 16-bit DAC control word or an 8-bit digital-potentiometer wiper word and shifts it out on a shared three-wire serial bus. It drives the DAC frame-sync or one of four potentiometer chip-selects. It reports busy and done, so the control logic can gate further commands.

## Interface
Parameters:
- `CLK_DIV`, default 2: clk cycles per SCLK half-period; legal range ≥1.
- `DAC_BITS`, default 16: DAC frame length in bits.
- `DPOT_BITS`, default 8: potentiometer frame length in bits; must be ≤ `DAC_BITS`.

Ports:
- `clk`  in  1: single system clock; all logic is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `dac_start`  in  1: 1-cycle request to send `dac_word`.
- `dac_word`  in  16: DAC word, e.g. `{ctrl[3:0], data[11:0]}`; sent MSB first.
- `dpot_start`  in  1: 1-cycle request to send `dpot_word`.
- `dpot_word`  in  8: wiper value; sent MSB first.
- `dpot_sel`  in  2: selects which of the four potentiometers to address.
- `busy`  out  1: a frame is in progress.
- `done`  out  1: 1-cycle pulse at the end of a frame.
- `sclk`  out  1: serial clock; idles low.
- `sdo`  out  1: serial data.
- `dac_sync_n`  out  1: DAC frame sync, active low.
- `dpot_cs_n`  out  4: potentiometer chip-selects, one-hot active low.

## Operation
- **Reset values:** `busy`=0, `done`=0, `sclk`=0, `sdo`=0, `dac_sync_n`=1, `dpot_cs_n`=4'b1111. FSM goes to IDLE.
- **FSM states:** IDLE → SETUP → SHIFT → END → IDLE.
- **IDLE:**
  - On `dac_start`, latch `dac_word` into the 16-bit shift register and set target=DAC, N=`DAC_BITS`.
  - Otherwise, on `dpot_start`, latch `{dpot_word, 8'h00}` (left-justified), latch `dpot_sel`, and set target=DPOT, N=`DPOT_BITS`.
- **SETUP:** assert the target select low, drive `sdo`=shift MSB, hold `sclk`=0. Lasts `CLK_DIV` cycles.
- **SHIFT:** N bits. For each bit, `sclk` is high for `CLK_DIV` cycles, then low for `CLK_DIV` cycles.
  - The peripheral samples on the rising edge.
  - The shift register advances and `sdo` takes the next bit on the falling edge of `sclk`, except after the last bit.
- **END:** 1 cycle. The select deasserts, `done`=1, `busy`=0 on the following cycle. The FSM returns to IDLE.
- **Busy window:** `busy`=1 from the first SETUP cycle through the END cycle inclusive.
- **Start while busy:** `dac_start` and `dpot_start` are ignored, not queued.
- **Simultaneous starts in IDLE:** DAC wins; the dpot request is dropped.
- **Select outputs:** only one select is ever low. `dpot_cs_n[i]`=0 only for the latched `dpot_sel`, never from the live input. `dac_sync_n` and `dpot_cs_n` are never low together.
- **Bit counter:** width `$clog2(DAC_BITS+1)`; counts down from N to 0 with no wrap. The divider counter is `$clog2(CLK_DIV)` bits (min 1) and reloads at each phase end.
- **Async reset mid-frame:** all outputs go to their reset values immediately, with no partial-frame completion.

## Timing
- **Start latency:** start sampled at edge k → select low and `sdo`=MSB at edge k+1.
- **Select low time:** `CLK_DIV*(1+2N)` cycles. With defaults: DAC = 66, DPOT = 34.
- **Frame end:** `done` pulses at the edge where the select returns high, i.e. at edge k+1+`CLK_DIV*(1+2N)`.
- **Back-to-back frames:** the earliest next accepted start is at the edge after `done`, so there is at least 1 idle cycle with the select high between frames.
- **Setup/hold:** `sdo` is stable ≥`CLK_DIV` cycles before and after each `sclk` rising edge.

## Structure
- **Shared package:** FSM state encoding (IDLE/SETUP/SHIFT/END), target enum (DAC/DPOT), and the default frame lengths 16 and 8.
- **Sub-module `spi_phase_tick`:** the `CLK_DIV` divider. It emits a 1-cycle phase-end tick while enabled and clears when disabled. The top level holds the FSM, shift register, bit counter and select decode.

## Test plan
- **DAC frame:** `CLK_DIV`=2, `dac_word`=16'hE800, `dac_start` pulse.
  - `sdo` at 16 `sclk` rising edges = 1110_1000_0000_0000.
  - `dac_sync_n` low 66 cycles; `done` at start+67; `dpot_cs_n` stays 4'hF.
- **Potentiometer frame:** `dpot_sel`=2, `dpot_word`=8'h81, `dpot_start`.
  - `dpot_cs_n`=4'b1011 for 34 cycles.
  - 8 rising edges carrying 1000_0001; `dac_sync_n` stays 1.
- **Start while busy:** `dac_start` at start+10 during a DAC frame → ignored; exactly 16 rising edges; a single `done`.
- **Simultaneous starts in IDLE:** `dac_start` and `dpot_start` asserted together → DAC frame only; no dpot select activity.
- **Reset mid-frame:** `rst` asserted at bit 5 of a DAC frame → `sclk`=0, `dac_sync_n`=1, `busy`=0 without waiting for an edge. The next `dac_start` produces a full 16-bit frame.
- **Fastest divider:** `CLK_DIV`=1 → DAC select low 33 cycles; `sclk` toggles every cycle; data correct.
